// File: rtl/lampboard_pkg.sv
// rtl/lampboard_pkg.sv - shared lamp map, FSM state type and lamp-count limit for lampboard_driver
package lampboard_pkg;

  localparam int MAX_LAMPS = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LIT  = 1'b1
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [4:0] idx;
  } lamp_map_t;

  // Expects an already upper-cased character; ok=0 for anything outside A..Z.
  function automatic lamp_map_t map_char(input logic [7:0] ch);
    lamp_map_t m;
    m.ok  = 1'b1;
    m.idx = 5'd0;
    case (ch)
      8'h41: m.idx = 5'd2;
      8'h42: m.idx = 5'd18;
      8'h43: m.idx = 5'd12;
      8'h44: m.idx = 5'd0;
      8'h45: m.idx = 5'd7;
      8'h46: m.idx = 5'd11;
      8'h47: m.idx = 5'd14;
      8'h48: m.idx = 5'd17;
      8'h49: m.idx = 5'd27;
      8'h4A: m.idx = 5'd20;
      8'h4B: m.idx = 5'd23;
      8'h4C: m.idx = 5'd26;
      8'h4D: m.idx = 5'd16;
      8'h4E: m.idx = 5'd21;
      8'h4F: m.idx = 5'd25;
      8'h50: m.idx = 5'd3;
      8'h51: m.idx = 5'd1;
      8'h52: m.idx = 5'd10;
      8'h53: m.idx = 5'd5;
      8'h54: m.idx = 5'd13;
      8'h55: m.idx = 5'd19;
      8'h56: m.idx = 5'd15;
      8'h57: m.idx = 5'd4;
      8'h58: m.idx = 5'd9;
      8'h59: m.idx = 5'd6;
      8'h5A: m.idx = 5'd8;
      default: m.ok = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lamp_hold_timer.sv
// rtl/lamp_hold_timer.sv - load/countdown hold timer; expire is high on the last held cycle
module lamp_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  output logic expire
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(HOLD_CYCLES);
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign expire = (count == TW'(1));

endmodule

// File: rtl/lampboard_driver.sv
// rtl/lampboard_driver.sv - one-hot lampboard driver with hold timer; LAMPBOARD_BLINK_EN adds lamp blinking
module lampboard_driver
  import lampboard_pkg::*;
#(
  parameter int NUM_LAMPS   = 26,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 6_250_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_char,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [NUM_LAMPS-1:0] lamps,
  output logic                 busy,
  output logic                 err_invalid
);

  if (NUM_LAMPS < 26 || NUM_LAMPS > MAX_LAMPS) begin : g_bad_num_lamps
    $error("NUM_LAMPS out of range");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 2");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end

  logic [7:0] folded;
  lamp_map_t  mapped;
  logic       mappable;
  logic       accept;
  logic       take;
  logic       expire;
  logic       lamp_on;
  logic [4:0] idx;
  state_t     state;
  state_t     state_nxt;

  assign folded   = (in_char >= 8'h61 && in_char <= 8'h7A) ? (in_char - 8'h20) : in_char;
  assign mapped   = map_char(folded);
  assign mappable = mapped.ok && (32'(mapped.idx) < NUM_LAMPS);
  assign in_ready = ~clear;
  assign accept   = in_valid & in_ready;
  assign take     = accept & mappable;

  lamp_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (take),
    .clr   (clear),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A new character beats a simultaneous expiry; clear beats everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_LIT;
      ST_LIT: begin
        if (take)        state_nxt = ST_LIT;
        else if (expire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 5'd0;
      err_invalid <= 1'b0;
    end else begin
      if (take) idx <= mapped.idx;
      err_invalid <= accept & ~mappable;
    end
  end

`ifdef LAMPBOARD_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (clear) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (take) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state == ST_LIT) begin
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign lamp_on = blink_on;
`else
  assign lamp_on = 1'b1;
`endif

  assign busy  = (state == ST_LIT);
  assign lamps = (busy && lamp_on) ? (NUM_LAMPS'(1) << idx) : '0;

endmodule

// File: tb/tb_lampboard_driver.sv
// tb/tb_lampboard_driver.sv - scoreboard bench for lampboard_driver with a cycle-level reference model
module tb_lampboard_driver;

  localparam int NL = 28;
  localparam int HC = 8;
  localparam int BH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          clear;
  logic [NL-1:0] lamps;
  logic          busy;
  logic          err_invalid;

  always #5 clk = ~clk;

  lampboard_driver #(
    .NUM_LAMPS  (NL),
    .HOLD_CYCLES(HC),
    .BLINK_HALF (BH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .clear      (clear),
    .lamps      (lamps),
    .busy       (busy),
    .err_invalid(err_invalid)
  );

  typedef struct {
    int            cyc;
    logic [NL-1:0] lamps;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   map_tab[26] = '{2, 18, 12, 0, 7, 11, 14, 17, 27, 20, 23, 26, 16,
                        21, 25, 3, 1, 10, 5, 13, 19, 15, 4, 9, 6, 8};
  int   cur_idx  = -1;
  int   age      = 0;
  logic [7:0] edge_chars[4] = '{8'h40, 8'h5B, 8'h60, 8'h7B};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_index(input logic [7:0] ch);
    int c;
    c = int'(ch);
    if (c >= 97 && c <= 122) c = c - 32;
    if (c < 65 || c > 90) return -1;
    if (map_tab[c-65] >= NL) return -1;
    return map_tab[c-65];
  endfunction

  function automatic logic [NL-1:0] ref_lamps();
    logic [NL-1:0] v;
    v = '0;
    if (cur_idx < 0) return v;
`ifdef LAMPBOARD_BLINK_EN
    if (((age / BH) % 2) != 0) return v;
`endif
    v[cur_idx] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, and queue what the DUT must show next cycle.
  task automatic step(input logic clr, input logic v, input logic [7:0] ch);
    exp_t e;
    int   ix;
    @(posedge clk);
    #1;
    clear    = clr;
    in_valid = v;
    in_char  = ch;
    e.err = 1'b0;
    if (clr) begin
      cur_idx = -1;
      age     = 0;
    end else begin
      ix = v ? ref_index(ch) : -1;
      if (v && ix < 0) e.err = 1'b1;
      if (ix >= 0) begin
        cur_idx = ix;
        age     = 0;
      end else if (cur_idx >= 0) begin
        age++;
        if (age >= HC) cur_idx = -1;
      end
    end
    e.cyc   = cyc + 1;
    e.lamps = ref_lamps();
    e.busy  = (cur_idx >= 0);
    sb.push_back(e);
    #1;
    chk("in_ready", 32'(in_ready), 32'(!clr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_mid_hold();
    @(posedge clk);
    #5;
    sb.delete();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_lamps", 32'(lamps), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    cur_idx = -1;
    age     = 0;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("lamps", 32'(lamps), 32'(mon_e.lamps));
      chk("busy", 32'(busy), 32'(mon_e.busy));
      chk("err_invalid", 32'(err_invalid), 32'(mon_e.err));
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_lamps", 32'(lamps), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err_invalid), 32'd0);
    #2;
    rst_n = 1'b1;

    step(1'b0, 1'b1, 8'h41);
    idle(10);

    step(1'b0, 1'b1, 8'h71);
    idle(2);
    step(1'b0, 1'b1, 8'h49);
    idle(10);

    step(1'b0, 1'b1, 8'h45);
    idle(2);
    step(1'b0, 1'b1, 8'h35);
    idle(8);

    step(1'b0, 1'b1, 8'h4D);
    idle(2);
    step(1'b1, 1'b1, 8'h5A);
    idle(3);

    // New character arrives on the very last held cycle
    step(1'b0, 1'b1, 8'h43);
    idle(7);
    step(1'b0, 1'b1, 8'h44);
    idle(9);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, edge_chars[i]);
    step(1'b0, 1'b1, 8'h7A);
    step(1'b0, 1'b1, 8'h61);
    idle(9);

    step(1'b0, 1'b1, 8'h4B);
    idle(3);
    reset_mid_hold();
    step(1'b0, 1'b1, 8'h44);
    idle(9);

    step(1'b0, 1'b1, 8'h42);
    idle(9);

    for (int i = 0; i < 400; i++) begin
      logic       c;
      logic       v;
      logic [7:0] ch;
      c = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       ch = 8'h41 + 8'($urandom_range(0, 25));
        1:       ch = 8'h61 + 8'($urandom_range(0, 25));
        2:       ch = 8'($urandom);
        default: ch = edge_chars[$urandom_range(0, 3)];
      endcase
      step(c, v, ch);
    end
    idle(10);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
